// File: rtl/clock_generator_multi_if.sv
// Control and status bus of the multi-channel clock divider.
// The master drives enables and divisor writes; the slave returns clocks, ticks and pending flags.
interface clock_generator_multi_if #(
   parameter int unsigned N_CHANNELS = 4,
   parameter int unsigned DIV_WIDTH  = 24
);
   localparam int unsigned CHAN_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

   logic [N_CHANNELS-1:0] en;
   logic                  wr_en;
   logic [CHAN_W-1:0]     wr_chan;
   logic [DIV_WIDTH-1:0]  wr_half_period;
   logic [N_CHANNELS-1:0] clk_salida;
   logic [N_CHANNELS-1:0] tick;
   logic [N_CHANNELS-1:0] pending;

   modport master (
      output en, wr_en, wr_chan, wr_half_period,
      input  clk_salida, tick, pending
   );

   modport slave (
      input  en, wr_en, wr_chan, wr_half_period,
      output clk_salida, tick, pending
   );
endinterface

// File: rtl/clock_generator_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor reload at toggle boundaries.
// Each channel produces a 50% duty clock of period 2*max(1,half_period) and a rising-edge tick.
module clock_generator_multi #(
   parameter int unsigned SYS_CLK_HZ   = 50000000,
   parameter int unsigned N_CHANNELS   = 4,
   parameter int unsigned DIV_WIDTH    = 24,
   parameter int unsigned DEFAULT_FREQ = 10000
) (
   input  logic                    clk_FPGA,
   input  logic                    reset,
   clock_generator_multi_if.slave  bus
);
   localparam int unsigned HP0 = SYS_CLK_HZ / (2 * DEFAULT_FREQ);
   localparam logic [DIV_WIDTH-1:0] HP0_V = DIV_WIDTH'(HP0);
   localparam logic [DIV_WIDTH-1:0] ONE_V = DIV_WIDTH'(1);

   logic [N_CHANNELS-1:0] clk_vec;
   logic [N_CHANNELS-1:0] tick_vec;
   logic [N_CHANNELS-1:0] pend_vec;

   for (genvar i = 0; i < int'(N_CHANNELS); i++) begin : g_ch
      logic [DIV_WIDTH-1:0] cnt_q;
      logic [DIV_WIDTH-1:0] active_hp_q;
      logic [DIV_WIDTH-1:0] shadow_hp_q;
      logic                 clk_q;
      logic                 tick_q;
      logic                 pend_q;
      logic [DIV_WIDTH-1:0] eff_c;
      logic                 run_c;
      logic                 bound_c;
      logic                 wr_hit_c;

      // A high output keeps counting after en drops so the high phase is never cut short.
      assign eff_c    = (active_hp_q == '0) ? ONE_V : active_hp_q;
      assign run_c    = bus.en[i] | clk_q;
      assign bound_c  = run_c && (cnt_q == (eff_c - ONE_V));
      assign wr_hit_c = bus.wr_en && (32'(bus.wr_chan) == 32'(i));

      // Boundary reload uses the pre-edge shadow; a same-edge write re-arms pending.
      always_ff @(posedge clk_FPGA or negedge reset) begin
         if (!reset) begin
            cnt_q       <= '0;
            active_hp_q <= HP0_V;
            shadow_hp_q <= HP0_V;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
            pend_q      <= 1'b0;
         end else begin
            if (bound_c) begin
               clk_q  <= ~clk_q;
               tick_q <= ~clk_q;
               cnt_q  <= '0;
            end else begin
               tick_q <= 1'b0;
               cnt_q  <= run_c ? (cnt_q + ONE_V) : '0;
            end
            if (bound_c && pend_q) begin
               active_hp_q <= shadow_hp_q;
               pend_q      <= 1'b0;
            end
            if (wr_hit_c) begin
               shadow_hp_q <= bus.wr_half_period;
               pend_q      <= 1'b1;
            end
         end
      end

      assign clk_vec[i]  = clk_q;
      assign tick_vec[i] = tick_q;
      assign pend_vec[i] = pend_q;
   end

   assign bus.clk_salida = clk_vec;
   assign bus.tick       = tick_vec;
   assign bus.pending    = pend_vec;
endmodule

// File: tb/tb_clock_generator_multi.sv
// Directed bench for clock_generator_multi (HP0=5, 4 channels, 8-bit divisors).
// A cycle-level behavioural model is checked every cycle, with literal pins at key points.
module tb_clock_generator_multi;
   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 8;
   localparam int          HP0 = 5;

   logic clk_FPGA = 1'b0;
   logic reset    = 1'b0;

   clock_generator_multi_if #(.N_CHANNELS(NCH), .DIV_WIDTH(DW)) bus ();

   clock_generator_multi #(
      .SYS_CLK_HZ(1000), .N_CHANNELS(NCH), .DIV_WIDTH(DW), .DEFAULT_FREQ(100)
   ) dut (
      .clk_FPGA (clk_FPGA),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 clk_FPGA = ~clk_FPGA;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   // Model: each half-phase lasts len cycles; a pending divisor becomes the next phase length.
   logic [3:0] m_out, m_tick, m_pend;
   int m_len [NCH];
   int m_el  [NCH];
   int m_sh  [NCH];

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   always @(posedge clk_FPGA or negedge reset) begin
      if (!reset) begin
         m_out = '0; m_tick = '0; m_pend = '0;
         for (int i = 0; i < int'(NCH); i++) begin
            m_len[i] = HP0; m_sh[i] = HP0; m_el[i] = 0;
         end
      end else begin
         for (int i = 0; i < int'(NCH); i++) begin
            m_tick[i] = 1'b0;
            if (bus.en[i] || m_out[i]) begin
               m_el[i]++;
               if (m_el[i] == m_len[i]) begin
                  m_out[i]  = ~m_out[i];
                  m_tick[i] = m_out[i];
                  m_el[i]   = 0;
                  if (m_pend[i]) begin
                     m_len[i]  = eff(m_sh[i]);
                     m_pend[i] = 1'b0;
                  end
               end
            end else begin
               m_el[i] = 0;
            end
            if (bus.wr_en && int'(bus.wr_chan) == i) begin
               m_sh[i]   = int'(bus.wr_half_period);
               m_pend[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk_FPGA) begin
      chk("model_clk_salida", bus.clk_salida, m_out);
      chk("model_tick", bus.tick, m_tick);
      chk("model_pending", bus.pending, m_pend);
   end

   task automatic nedge(input int n);
      repeat (n) @(negedge clk_FPGA);
   endtask

   task automatic write(input int c, input int v);
      bus.wr_en          = 1'b1;
      bus.wr_chan        = 2'(c);
      bus.wr_half_period = DW'(v);
      nedge(1);
      bus.wr_en = 1'b0;
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", nm, $time);
   endtask

   initial begin
      bus.en = '0; bus.wr_en = 1'b0; bus.wr_chan = '0; bus.wr_half_period = '0;
      nedge(2);
      chk("reset_clk", bus.clk_salida, 4'b0000);
      chk("reset_tick", bus.tick, 4'b0000);
      chk("reset_pending", bus.pending, 4'b0000);

      // Release with all channels enabled: 5 low, 5 high.
      bus.en = 4'b1111; reset = 1'b1;
      nedge(4);  chk("first_low", bus.clk_salida, 4'b0000);
      nedge(1);  chk("first_rise", bus.clk_salida, 4'b1111);
                 chk("first_tick", bus.tick, 4'b1111);
      nedge(1);  chk("tick_one_cycle", bus.tick, 4'b0000);
                 chk("still_high", bus.clk_salida, 4'b1111);
      nedge(4);  chk("first_fall", bus.clk_salida, 4'b0000);
      nedge(5);  chk("second_rise", bus.tick, 4'b1111);

      // Channel 2 to half-period 3 mid high phase.
      nedge(1);
      write(2, 3);
      chk("ch2_pending_set", bus.pending, 4'b0100);
      nedge(3);  chk("ch2_pending_clear", bus.pending, 4'b0000);
                 chk("fall_all", bus.clk_salida, 4'b0000);
      nedge(3);  chk("ch2_fast_rise", bus.clk_salida, 4'b0100);
                 chk("ch2_fast_tick", bus.tick, 4'b0100);
      nedge(2);  chk("others_rise", bus.clk_salida, 4'b1111);
                 chk("others_tick", bus.tick, 4'b1011);

      // Channel 1 to half-period 0 (treated as 1).
      write(1, 0);
      nedge(20);

      // Disable channel 0 two cycles into a high phase.
      begin
         bit found = 1'b0;
         for (int k = 0; k < 30; k++) begin
            nedge(1);
            if (m_tick[0]) begin found = 1'b1; break; end
         end
         if (!found) timeout("wait_ch0_rise");
      end
      nedge(1);
      bus.en[0] = 1'b0;
      nedge(3);  chk("ch0_hold_high", {3'b0, bus.clk_salida[0]}, 4'b0001);
      nedge(1);  chk("ch0_fall", {3'b0, bus.clk_salida[0]}, 4'b0000);
      nedge(5);  chk("ch0_stopped", {3'b0, bus.clk_salida[0]}, 4'b0000);
      bus.en[0] = 1'b1;
      nedge(4);  chk("ch0_restart_low", {3'b0, bus.clk_salida[0]}, 4'b0000);
      nedge(1);  chk("ch0_restart_rise", {3'b0, bus.clk_salida[0]}, 4'b0001);
                 chk("ch0_restart_tick", {3'b0, bus.tick[0]}, 4'b0001);

      // Two writes to channel 3, the second on its boundary.
      begin
         bit found = 1'b0;
         for (int k = 0; k < 30; k++) begin
            if (m_len[3] >= 2 && m_el[3] == m_len[3] - 2) begin found = 1'b1; break; end
            nedge(1);
         end
         if (!found) timeout("wait_ch3_boundary");
      end
      bus.wr_en = 1'b1; bus.wr_chan = 2'd3; bus.wr_half_period = 8'd7;
      nedge(1);
      bus.wr_half_period = 8'd4;
      nedge(1);
      bus.wr_en = 1'b0;
      chk("ch3_pending_after_boundary", {3'b0, bus.pending[3]}, 4'b0001);
      nedge(6);  chk("ch3_pending_held", {3'b0, bus.pending[3]}, 4'b0001);
      nedge(1);  chk("ch3_pending_clear", {3'b0, bus.pending[3]}, 4'b0000);
      nedge(12);

      // Asynchronous reset with a write outstanding.
      bus.en = 4'b1111;
      write(0, 2);
      #2 reset = 1'b0;
      #1 chk("async_rst_clk", bus.clk_salida, 4'b0000);
         chk("async_rst_tick", bus.tick, 4'b0000);
         chk("async_rst_pending", bus.pending, 4'b0000);
      nedge(1);
      reset = 1'b1;
      nedge(4);  chk("post_rst_low", bus.clk_salida, 4'b0000);
      nedge(1);  chk("post_rst_rise", bus.clk_salida, 4'b1111);
                 chk("post_rst_tick", bus.tick, 4'b1111);
      nedge(5);  chk("post_rst_fall", bus.clk_salida, 4'b0000);
      nedge(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
